// File: rtl/corr_max_receiver_pkg.sv
// Shared definitions for the correlator compare-tree output link receiver.
// Holds the lock FSM encoding and the training word defaults shared with the compare tree.
package corr_max_receiver_pkg;

  localparam int unsigned NumBitsDef     = 12;
  localparam int unsigned NumCorrBitsDef = 4;
  localparam int unsigned PatternW       = 18;

  // Field split: max = [NUM_BITS-1:0], index = [NUM_BITS +: NUM_CORR_BITS].
  localparam logic [PatternW-1:0] TrainingPatternDef = 18'h2B7ED;

  typedef enum logic [1:0] {
    StUnlocked,
    StSearch,
    StTrainOk,
    StRun
  } rx_state_e;

endpackage

// File: rtl/corr_train_checker.sv
// Training-pattern lock tracker: delays train by the tree latency, counts consecutive
// matching words, keeps a saturating mismatch count and runs the lock FSM.
module corr_train_checker
  import corr_max_receiver_pkg::*;
#(
  parameter int unsigned          NUM_BITS         = NumBitsDef,
  parameter int unsigned          NUM_CORR_BITS    = NumCorrBitsDef,
  parameter logic [PatternW-1:0]  TRAINING_PATTERN = TrainingPatternDef,
  parameter int unsigned          TRAIN_LATENCY    = 3,
  parameter int unsigned          LOCK_COUNT       = 16,
  parameter int unsigned          ERR_BITS         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_BITS-1:0]      max_i,
  input  logic [NUM_CORR_BITS-1:0] idx_i,
  input  logic                     train_i,
  input  logic                     err_clr_i,
  output rx_state_e                state_o,
  output logic                     trn_d_o,
  output logic [ERR_BITS-1:0]      err_cnt_o
);

  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);
  localparam logic [NUM_BITS-1:0]      PatMax = TRAINING_PATTERN[NUM_BITS-1:0];
  localparam logic [NUM_CORR_BITS-1:0] PatIdx = TRAINING_PATTERN[NUM_BITS +: NUM_CORR_BITS];

  // TRAIN_LATENCY must be at least 2 for this shift register form.
  logic [TRAIN_LATENCY-1:0] trn_sr_q;
  rx_state_e                state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [ERR_BITS-1:0]      err_q, err_d;
  logic                     trn_d, match, err_inc;

  assign trn_d = trn_sr_q[TRAIN_LATENCY-1];
  assign match = (max_i == PatMax) && (idx_i == PatIdx);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trn_sr_q <= '0;
      state_q  <= StUnlocked;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      trn_sr_q <= {trn_sr_q[TRAIN_LATENCY-2:0], train_i};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_inc = 1'b0;
    case (state_q)
      StUnlocked: begin
        if (trn_d) begin
          state_d = StSearch;
          cnt_d   = '0;
        end
      end
      StSearch: begin
        if (!trn_d) begin
          state_d = StUnlocked;
        end else if (match) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(LOCK_COUNT - 1)) state_d = StTrainOk;
        end else begin
          cnt_d   = '0;
          err_inc = 1'b1;
        end
      end
      // Once train has dropped the link carries live data, so it is no longer checked.
      StTrainOk: begin
        if (!trn_d) begin
          state_d = StRun;
        end else if (!match) begin
          state_d = StSearch;
          cnt_d   = '0;
          err_inc = 1'b1;
        end
      end
      StRun: begin
        if (trn_d) begin
          state_d = StSearch;
          cnt_d   = '0;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i) begin
      err_d = '0;
    end else if (err_inc && (err_q != '1)) begin
      err_d = err_q + ERR_BITS'(1);
    end
  end

  assign state_o   = state_q;
  assign trn_d_o   = trn_d;
  assign err_cnt_o = err_q;

endmodule

// File: rtl/corr_max_receiver.sv
// Receiving end of the correlator compare-tree link: registers the {max, index} word,
// tracks training lock and, in run mode, issues holdoff-limited threshold triggers.
module corr_max_receiver
  import corr_max_receiver_pkg::*;
#(
  parameter int unsigned          NUM_BITS         = NumBitsDef,
  parameter int unsigned          NUM_CORR_BITS    = NumCorrBitsDef,
  parameter logic [PatternW-1:0]  TRAINING_PATTERN = TrainingPatternDef,
  parameter int unsigned          TRAIN_LATENCY    = 3,
  parameter int unsigned          LOCK_COUNT       = 16,
  parameter int unsigned          HOLDOFF          = 8,
  parameter int unsigned          ERR_BITS         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_BITS-1:0]      max_i,
  input  logic [NUM_CORR_BITS-1:0] maxcorr_i,
  input  logic                     train_i,
  input  logic [NUM_BITS-1:0]      threshold_i,
  input  logic                     err_clr_i,
  output logic                     locked_o,
  output logic                     run_o,
  output logic                     trig_o,
  output logic [NUM_BITS-1:0]      trig_max_o,
  output logic [NUM_CORR_BITS-1:0] trig_idx_o,
  output logic [ERR_BITS-1:0]      err_cnt_o
);

  localparam int unsigned HoldW = $clog2(HOLDOFF + 1);

  logic [NUM_BITS-1:0]      max_q, trig_max_q;
  logic [NUM_CORR_BITS-1:0] idx_q, trig_idx_q;
  logic [HoldW-1:0]         hold_q, hold_d;
  logic                     trig_q, fire, trn_d;
  rx_state_e                state;

  corr_train_checker #(
    .NUM_BITS         (NUM_BITS),
    .NUM_CORR_BITS    (NUM_CORR_BITS),
    .TRAINING_PATTERN (TRAINING_PATTERN),
    .TRAIN_LATENCY    (TRAIN_LATENCY),
    .LOCK_COUNT       (LOCK_COUNT),
    .ERR_BITS         (ERR_BITS)
  ) u_train_checker (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .max_i     (max_q),
    .idx_i     (idx_q),
    .train_i   (train_i),
    .err_clr_i (err_clr_i),
    .state_o   (state),
    .trn_d_o   (trn_d),
    .err_cnt_o (err_cnt_o)
  );

  // A retrain request arriving in RUN takes priority over a trigger in the same cycle.
  assign fire = (state == StRun) && !trn_d && (hold_q == '0) && (max_q >= threshold_i);

  always_comb begin
    hold_d = hold_q;
    if (state != StRun) begin
      hold_d = '0;
    end else if (fire) begin
      hold_d = HoldW'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      max_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      trig_q     <= 1'b0;
      trig_max_q <= '0;
      trig_idx_q <= '0;
    end else begin
      max_q  <= max_i;
      idx_q  <= maxcorr_i;
      hold_q <= hold_d;
      trig_q <= fire;
      if (fire) begin
        trig_max_q <= max_q;
        trig_idx_q <= idx_q;
      end
    end
  end

  assign locked_o   = (state == StTrainOk) || (state == StRun);
  assign run_o      = (state == StRun);
  assign trig_o     = trig_q;
  assign trig_max_o = trig_max_q;
  assign trig_idx_o = trig_idx_q;

endmodule

// File: tb/tb_corr_max_receiver.sv
// Directed bench for corr_max_receiver: a cycle model built from the behavioural rules is
// compared against the DUT every negedge, plus hand-computed checks at key cycles.
module tb_corr_max_receiver;

  localparam logic [11:0] PAT_MAX = 12'h7ED;
  localparam logic [3:0]  PAT_IDX = 4'hB;
  localparam int M_UNL = 0, M_SRCH = 1, M_OK = 2, M_RUN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] max_in = '0;
  logic [3:0]  idx_in = '0;
  logic        train = 1'b0;
  logic [11:0] thr = 12'hFFF;
  logic        err_clr = 1'b0;
  logic        locked, run, trig;
  logic [11:0] trig_max;
  logic [3:0]  trig_idx;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  corr_max_receiver dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .max_i       (max_in),
    .maxcorr_i   (idx_in),
    .train_i     (train),
    .threshold_i (thr),
    .err_clr_i   (err_clr),
    .locked_o    (locked),
    .run_o       (run),
    .trig_o      (trig),
    .trig_max_o  (trig_max),
    .trig_idx_o  (trig_idx),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: history of train samples, registered word, mode, streak, counters.
  bit          m_hist[$];
  logic [11:0] m_max = '0, m_tmax = '0;
  logic [3:0]  m_idx = '0, m_tidx = '0;
  int          m_mode = M_UNL, m_streak = 0, m_err = 0, m_hold = 0;
  bit          m_trig = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit trn, good, fire, bump;
    if (!rst_n) begin
      m_hist.delete();
      m_max = '0; m_idx = '0; m_tmax = '0; m_tidx = '0;
      m_mode = M_UNL; m_streak = 0; m_err = 0; m_hold = 0; m_trig = 1'b0;
    end else begin
      trn  = (m_hist.size() >= 3) ? m_hist[m_hist.size()-3] : 1'b0;
      good = (m_max == PAT_MAX) && (m_idx == PAT_IDX);
      fire = (m_mode == M_RUN) && !trn && (m_hold == 0) && (m_max >= thr);
      bump = trn && (m_mode == M_SRCH || m_mode == M_OK) && !good;
      if (err_clr) m_err = 0;
      else if (bump && m_err < 65535) m_err = m_err + 1;
      if (m_mode != M_RUN) m_hold = 0;
      else if (fire) m_hold = 8;
      else if (m_hold > 0) m_hold = m_hold - 1;
      m_trig = fire;
      if (fire) begin
        m_tmax = m_max;
        m_tidx = m_idx;
      end
      case (m_mode)
        M_UNL:  if (trn) begin m_mode = M_SRCH; m_streak = 0; end
        M_SRCH: begin
          if (!trn) m_mode = M_UNL;
          else if (good) begin
            m_streak = m_streak + 1;
            if (m_streak == 16) m_mode = M_OK;
          end else m_streak = 0;
        end
        M_OK:   if (!trn) m_mode = M_RUN;
                else if (!good) begin m_mode = M_SRCH; m_streak = 0; end
        default: if (trn) begin m_mode = M_SRCH; m_streak = 0; end
      endcase
      m_max = max_in;
      m_idx = idx_in;
      m_hist.push_back(train);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_locked", {31'd0, locked}, {31'd0, m_mode >= M_OK});
      chk("cmp_run", {31'd0, run}, {31'd0, m_mode == M_RUN});
      chk("cmp_trig", {31'd0, trig}, {31'd0, m_trig});
      chk("cmp_trig_max", {20'd0, trig_max}, {20'd0, m_tmax});
      chk("cmp_trig_idx", {28'd0, trig_idx}, {28'd0, m_tidx});
      chk("cmp_err_cnt", {16'd0, err_cnt}, m_err);
    end
  end

  initial begin
    cmp_en = 1'b1;
    tick(3);
    chk("reset_locked", {31'd0, locked}, 0);
    chk("reset_err", {16'd0, err_cnt}, 0);
    chk("reset_trig", {31'd0, trig}, 0);
    rst_n = 1'b1;

    // Lock from reset: locked exactly 3 + 1 + 16 cycles after train rises.
    train = 1'b1; max_in = PAT_MAX; idx_in = PAT_IDX;
    tick(19);
    chk("lock_not_yet", {31'd0, locked}, 0);
    tick(1);
    chk("lock_at_20", {31'd0, locked}, 1);
    chk("lock_err0", {16'd0, err_cnt}, 0);

    // Single bad word drops lock two cycles later and needs 16 good words to relock.
    tick(5);
    max_in = 12'h7EC;
    tick(1);
    max_in = PAT_MAX;
    chk("bad_still_locked", {31'd0, locked}, 1);
    tick(1);
    chk("bad_lock_lost", {31'd0, locked}, 0);
    chk("bad_err1", {16'd0, err_cnt}, 1);
    tick(15);
    chk("relock_not_yet", {31'd0, locked}, 0);
    tick(1);
    chk("relock", {31'd0, locked}, 1);

    // Drop train: RUN four edges after the drop (3 delay + 1 state).
    tick(5);
    train = 1'b0; thr = 12'd100;
    tick(3);
    chk("run_not_yet", {31'd0, run}, 0);
    max_in = '0; idx_in = '0;
    tick(1);
    chk("run_entered", {31'd0, run}, 1);

    // Equality triggers with 2-cycle latency; one below does not.
    tick(2);
    max_in = 12'd100; idx_in = 4'd5;
    tick(1);
    max_in = '0; idx_in = '0;
    chk("thr_eq_early", {31'd0, trig}, 0);
    tick(1);
    chk("thr_eq_trig", {31'd0, trig}, 1);
    chk("thr_eq_max", {20'd0, trig_max}, 100);
    chk("thr_eq_idx", {28'd0, trig_idx}, 5);
    tick(1);
    chk("thr_eq_pulse", {31'd0, trig}, 0);
    chk("thr_eq_hold_max", {20'd0, trig_max}, 100);
    tick(12);
    max_in = 12'd99;
    tick(1);
    max_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("below_thr", {31'd0, trig}, 0);
    end

    // Constant high input: pulse every HOLDOFF+1 = 9 cycles.
    max_in = 12'd500; idx_in = 4'd3;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      chk("holdoff_period", {31'd0, trig}, {31'd0, (i >= 2) && ((i - 2) % 9 == 0)});
    end
    chk("holdoff_max", {20'd0, trig_max}, 500);

    // Saturate the error counter with continuous mismatching training words.
    train = 1'b1; max_in = '0; idx_in = '0;
    tick(65600);
    chk("err_sat", {16'd0, err_cnt}, 32'hFFFF);
    tick(5);
    chk("err_sat_hold", {16'd0, err_cnt}, 32'hFFFF);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr_wins", {16'd0, err_cnt}, 0);
    tick(1);
    chk("err_after_clr", {16'd0, err_cnt}, 1);

    // Relock from SEARCH, run, trigger, then reset during holdoff.
    max_in = PAT_MAX; idx_in = PAT_IDX;
    tick(16);
    chk("relock2_not_yet", {31'd0, locked}, 0);
    tick(1);
    chk("relock2", {31'd0, locked}, 1);
    train = 1'b0;
    tick(3);
    max_in = 12'd500; idx_in = 4'd7;
    tick(1);
    chk("run2", {31'd0, run}, 1);
    tick(1);
    chk("run2_trig", {31'd0, trig}, 1);
    chk("run2_idx", {28'd0, trig_idx}, 7);
    tick(2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_locked", {31'd0, locked}, 0);
    chk("async_run", {31'd0, run}, 0);
    chk("async_trig_max", {20'd0, trig_max}, 0);
    chk("async_trig_idx", {28'd0, trig_idx}, 0);
    chk("async_err", {16'd0, err_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("post_reset_no_trig", {31'd0, trig}, 0);
    end

    // Full retrain after reset restores triggering.
    train = 1'b1; max_in = PAT_MAX; idx_in = PAT_IDX;
    tick(20);
    chk("retrain_locked", {31'd0, locked}, 1);
    train = 1'b0;
    tick(3);
    max_in = 12'd500; idx_in = 4'd2;
    tick(2);
    chk("retrain_trig", {31'd0, trig}, 1);
    chk("retrain_idx", {28'd0, trig_idx}, 2);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
